// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE array sequencer.
// Holds the FSM state encoding, pixel width and accumulator sizing.
package pe_ctrl_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        SUM_START,
        SUM_WAIT,
        SUM_ACK,
        ACCUM,
        DIVIDE,
        BG_START,
        BG_WAIT,
        BG_ACK,
        DONE,
        ABORT
    } state_t;

    // Enough headroom to add NUM_PE full-scale pixels without wrapping.
    function automatic int acc_width(input int log2_num_pe);
        return PIX_W + log2_num_pe;
    endfunction

endpackage

// File: rtl/pe_sum_averager.sv
// One colour channel: serially accumulates per-PE sums, then divides by NUM_PE.
// Accumulator is widened so the average of full-scale inputs never saturates.
module pe_sum_averager
    import pe_ctrl_pkg::*;
#(
    parameter int LOG2_NUM_PE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             add_en,
    input  logic             divide,
    input  logic [PIX_W-1:0] sum,
    output logic [PIX_W-1:0] avg
);

    localparam int AW = acc_width(LOG2_NUM_PE);

    logic [AW-1:0] acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            avg <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (add_en) begin
                acc <= acc + AW'(sum);
            end
            if (divide) begin
                avg <= PIX_W'(acc >> LOG2_NUM_PE);
            end
        end
    end

endmodule

// File: rtl/pe_array_scheduler.sv
// Sequences sum phase, colour averaging and background-removal phase across the PE array.
// All outputs registered; waits abort after TIMEOUT cycles and raise a sticky Error.
module pe_array_scheduler
    import pe_ctrl_pkg::*;
#(
    parameter  int LOG2_NUM_PE = 2,
    parameter  int TIMEOUT     = 1000,
    localparam int NUM_PE      = 2 ** LOG2_NUM_PE
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [PIX_W-1:0]          threshold_in,
    input  logic [PIX_W-1:0]          bg_r_in,
    input  logic [PIX_W-1:0]          bg_g_in,
    input  logic [PIX_W-1:0]          bg_b_in,
    input  logic [NUM_PE-1:0]         Qsd,
    input  logic [NUM_PE-1:0]         Qbgd,
    input  logic [PIX_W*NUM_PE-1:0]   red_sum,
    input  logic [PIX_W*NUM_PE-1:0]   green_sum,
    input  logic [PIX_W*NUM_PE-1:0]   blue_sum,
    output logic                      Start_Sum,
    output logic                      Start_BgRemoval,
    output logic                      Ack,
    output logic [PIX_W-1:0]          red_exp,
    output logic [PIX_W-1:0]          green_exp,
    output logic [PIX_W-1:0]          blue_exp,
    output logic [PIX_W-1:0]          threshold,
    output logic [PIX_W-1:0]          desired_bg_r,
    output logic [PIX_W-1:0]          desired_bg_g,
    output logic [PIX_W-1:0]          desired_bg_b,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]          TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [LOG2_NUM_PE-1:0] IDX_LAST = LOG2_NUM_PE'(NUM_PE - 1);

    state_t                 state;
    logic [TW-1:0]          tmo_cnt;
    logic [LOG2_NUM_PE-1:0] idx;
    logic                   acc_clear;
    logic                   acc_add;
    logic                   acc_div;
    logic [PIX_W-1:0]       red_sel;
    logic [PIX_W-1:0]       green_sel;
    logic [PIX_W-1:0]       blue_sel;

    assign acc_clear = (state == SUM_ACK);
    assign acc_add   = (state == ACCUM);
    assign acc_div   = (state == DIVIDE);
    assign red_sel   = red_sum[int'(idx) * PIX_W +: PIX_W];
    assign green_sel = green_sum[int'(idx) * PIX_W +: PIX_W];
    assign blue_sel  = blue_sum[int'(idx) * PIX_W +: PIX_W];

    pe_sum_averager #(.LOG2_NUM_PE(LOG2_NUM_PE)) u_avg_red (
        .clk(Clk), .reset(Reset), .clear(acc_clear), .add_en(acc_add),
        .divide(acc_div), .sum(red_sel), .avg(red_exp)
    );

    pe_sum_averager #(.LOG2_NUM_PE(LOG2_NUM_PE)) u_avg_green (
        .clk(Clk), .reset(Reset), .clear(acc_clear), .add_en(acc_add),
        .divide(acc_div), .sum(green_sel), .avg(green_exp)
    );

    pe_sum_averager #(.LOG2_NUM_PE(LOG2_NUM_PE)) u_avg_blue (
        .clk(Clk), .reset(Reset), .clear(acc_clear), .add_en(acc_add),
        .divide(acc_div), .sum(blue_sel), .avg(blue_exp)
    );

    // Outputs are assigned on the transition into the state that owns them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= IDLE;
            tmo_cnt         <= '0;
            idx             <= '0;
            Start_Sum       <= 1'b0;
            Start_BgRemoval <= 1'b0;
            Ack             <= 1'b0;
            Done            <= 1'b0;
            Busy            <= 1'b0;
            Error           <= 1'b0;
            threshold       <= '0;
            desired_bg_r    <= '0;
            desired_bg_g    <= '0;
            desired_bg_b    <= '0;
        end else begin
            Start_Sum       <= 1'b0;
            Start_BgRemoval <= 1'b0;
            Ack             <= 1'b0;
            Done            <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        threshold    <= threshold_in;
                        desired_bg_r <= bg_r_in;
                        desired_bg_g <= bg_g_in;
                        desired_bg_b <= bg_b_in;
                        Error        <= 1'b0;
                        Busy         <= 1'b1;
                        Start_Sum    <= 1'b1;
                        state        <= SUM_START;
                    end
                end
                SUM_START: begin
                    tmo_cnt <= '0;
                    state   <= SUM_WAIT;
                end
                SUM_WAIT: begin
                    if (&Qsd) begin
                        Ack   <= 1'b1;
                        state <= SUM_ACK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        Ack   <= 1'b1;
                        Error <= 1'b1;
                        state <= ABORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SUM_ACK: begin
                    idx   <= '0;
                    state <= ACCUM;
                end
                ACCUM: begin
                    idx <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    Start_BgRemoval <= 1'b1;
                    state           <= BG_START;
                end
                BG_START: begin
                    tmo_cnt <= '0;
                    state   <= BG_WAIT;
                end
                BG_WAIT: begin
                    if (&Qbgd) begin
                        Ack   <= 1'b1;
                        state <= BG_ACK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        Ack   <= 1'b1;
                        Error <= 1'b1;
                        state <= ABORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                BG_ACK: begin
                    Done  <= 1'b1;
                    state <= DONE;
                end
                DONE, ABORT: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_array_scheduler.sv
// Randomised bench: a cycle-level model of the flag schedules predicts pulse timing,
// averaged colours, timeout aborts and reset behaviour for a 4-PE array.
module tb_pe_array_scheduler;

    localparam int NP  = 4;
    localparam int TMO = 20;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Start;
    logic [7:0]      threshold_in, bg_r_in, bg_g_in, bg_b_in;
    logic [NP-1:0]   Qsd, Qbgd;
    logic [8*NP-1:0] red_sum, green_sum, blue_sum;
    logic            Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error;
    logic [7:0]      red_exp, green_exp, blue_exp, threshold;
    logic [7:0]      desired_bg_r, desired_bg_g, desired_bg_b;

    int vectors = 0;
    int miscompares = 0;

    // Flag schedules per phase (0 = sum, 1 = bg): high from rise, low inside [drop, rerise).
    int rise[2][NP];
    int drop[2][NP];
    int rerise[2][NP];
    logic [7:0] rs[NP], gs[NP], bs[NP];

    always #5 Clk = ~Clk;

    pe_array_scheduler #(.LOG2_NUM_PE(2), .TIMEOUT(TMO)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .threshold_in(threshold_in),
        .bg_r_in(bg_r_in), .bg_g_in(bg_g_in), .bg_b_in(bg_b_in),
        .Qsd(Qsd), .Qbgd(Qbgd), .red_sum(red_sum), .green_sum(green_sum),
        .blue_sum(blue_sum), .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval),
        .Ack(Ack), .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
        .threshold(threshold), .desired_bg_r(desired_bg_r), .desired_bg_g(desired_bg_g),
        .desired_bg_b(desired_bg_b), .Busy(Busy), .Done(Done), .Error(Error)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit hi(input int ph, input int i, input int k);
        return (k >= rise[ph][i]) && !(k >= drop[ph][i] && k < rerise[ph][i]);
    endfunction

    // First wait cycle (1..TMO after the start pulse) on which every flag is high, else -1.
    function automatic int first_done(input int ph);
        for (int k = 1; k <= TMO; k++) begin
            bit all_hi = 1'b1;
            for (int i = 0; i < NP; i++) if (!hi(ph, i, k)) all_hi = 1'b0;
            if (all_hi) return k;
        end
        return -1;
    endfunction

    task automatic set_simple(input int ph, input int r);
        for (int i = 0; i < NP; i++) begin
            rise[ph][i] = r; drop[ph][i] = 0; rerise[ph][i] = 0;
        end
    endtask

    task automatic set_sums(input int r0, r1, r2, r3, g0, g1, g2, g3, b0, b1, b2, b3);
        rs[0] = 8'(r0); rs[1] = 8'(r1); rs[2] = 8'(r2); rs[3] = 8'(r3);
        gs[0] = 8'(g0); gs[1] = 8'(g1); gs[2] = 8'(g2); gs[3] = 8'(g3);
        bs[0] = 8'(b0); bs[1] = 8'(b1); bs[2] = 8'(b2); bs[3] = 8'(b3);
    endtask

    task automatic run_op(input bit glitch, input bit rst_mid);
        int ks, kb, e_ack1, e_bg, e_ack_last, e_done, e_idle, e_nack;
        int sr, sg, sb;
        bit sum_ab, bg_ab;
        int n_ss = 0, n_bg = 0, n_ack = 0, n_done = 0;
        int c_ss = -1, c_bg = -1, c_ack1 = -1, c_ack_last = -1, c_done = -1, c_idle = -1;
        int c_rst = -1;
        logic [7:0] thr, br, bgc, bb, er, eg, eb;

        ks = first_done(0);
        kb = first_done(1);
        sum_ab = (ks < 0);
        bg_ab  = !sum_ab && (kb < 0);
        e_ack1     = sum_ab ? 1 + TMO + 1 : 1 + ks + 1;
        e_bg       = sum_ab ? -1 : 1 + ks + 3 + NP;
        e_ack_last = sum_ab ? e_ack1 : (bg_ab ? e_bg + TMO + 1 : e_bg + kb + 1);
        e_nack     = sum_ab ? 1 : 2;
        e_done     = (sum_ab || bg_ab) ? -1 : e_bg + kb + 2;
        e_idle     = e_ack_last + ((sum_ab || bg_ab) ? 1 : 2);
        sr = 0; sg = 0; sb = 0;
        for (int i = 0; i < NP; i++) begin sr += rs[i]; sg += gs[i]; sb += bs[i]; end

        red_sum   = {rs[3], rs[2], rs[1], rs[0]};
        green_sum = {gs[3], gs[2], gs[1], gs[0]};
        blue_sum  = {bs[3], bs[2], bs[1], bs[0]};
        thr = 8'($urandom); br = 8'($urandom); bgc = 8'($urandom); bb = 8'($urandom);
        threshold_in = thr; bg_r_in = br; bg_g_in = bgc; bg_b_in = bb;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;

        for (int c = 1; c <= 150; c++) begin
            if (c_rst > 0) begin
                check_val("rst_busy", Busy, 0);
                check_val("rst_pulses", {Start_Sum, Start_BgRemoval, Ack, Done, Error}, 0);
                check_val("rst_exp", {red_exp, green_exp, blue_exp}, 0);
                check_val("rst_cfg", {threshold, desired_bg_r, desired_bg_g, desired_bg_b}, 0);
                Reset = 1'b0;
                Qsd = '0; Qbgd = '0;
                @(negedge Clk);
                return;
            end
            if (c == 1) check_val("err_clr", Error, 0);
            if (Start_Sum) begin n_ss++; c_ss = c; end
            if (Start_BgRemoval) begin
                n_bg++; c_bg = c;
                er = red_exp; eg = green_exp; eb = blue_exp;
            end
            if (Ack) begin
                n_ack++; c_ack_last = c;
                if (c_ack1 < 0) c_ack1 = c;
            end
            if (Done) begin n_done++; c_done = c; end
            if (c > 1 && !Busy) begin c_idle = c; break; end

            for (int i = 0; i < NP; i++) begin
                Qsd[i]  = hi(0, i, c - 1);
                Qbgd[i] = (c_bg > 0) ? hi(1, i, c - c_bg) : 1'b0;
            end
            if (glitch && c_bg > 0 && c == c_bg + 2) begin
                Start = 1'b1; threshold_in = ~thr;
            end else begin
                Start = 1'b0;
            end
            if (rst_mid && c_ack1 > 0 && c == c_ack1 + 2) begin
                Reset = 1'b1; c_rst = c;
            end
            @(negedge Clk);
        end

        Qsd = '0; Qbgd = '0; Start = 1'b0;
        check_val("ss_cnt", n_ss, 1);
        check_val("ss_cyc", c_ss, 1);
        check_val("ack1_cyc", c_ack1, e_ack1);
        check_val("bg_cyc", c_bg, e_bg);
        check_val("bg_cnt", n_bg, sum_ab ? 0 : 1);
        check_val("ack_cnt", n_ack, e_nack);
        check_val("ack_last_cyc", c_ack_last, e_ack_last);
        check_val("done_cyc", c_done, e_done);
        check_val("done_cnt", n_done, (e_done > 0) ? 1 : 0);
        check_val("idle_cyc", c_idle, e_idle);
        check_val("err_end", Error, (sum_ab || bg_ab) ? 1 : 0);
        check_val("cfg", {threshold, desired_bg_r, desired_bg_g, desired_bg_b}, {thr, br, bgc, bb});
        if (!sum_ab) begin
            check_val("red_exp", er, sr / NP);
            check_val("grn_exp", eg, sg / NP);
            check_val("blu_exp", eb, sb / NP);
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Qsd = '0; Qbgd = '0;
        threshold_in = '0; bg_r_in = '0; bg_g_in = '0; bg_b_in = '0;
        red_sum = '0; green_sum = '0; blue_sum = '0;
        repeat (3) @(negedge Clk);
        check_val("reset_ctl", {Busy, Done, Error, Ack, Start_Sum, Start_BgRemoval}, 0);
        check_val("reset_exp", {red_exp, green_exp, blue_exp}, 0);
        check_val("reset_cfg", {threshold, desired_bg_r, desired_bg_g, desired_bg_b}, 0);
        Reset = 1'b0;
        @(negedge Clk);

        set_sums(61, 63, 60, 62, 133, 133, 133, 133, 198, 199, 197, 198);
        set_simple(0, 3); set_simple(1, 4);
        run_op(1'b0, 1'b0);

        set_sums(255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255);
        set_simple(0, 1); set_simple(1, 1);
        run_op(1'b0, 1'b0);

        set_sums(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_simple(0, TMO); set_simple(1, TMO);
        run_op(1'b0, 1'b0);

        // Staggered flags with bit 2 dropping and re-rising last.
        set_sums(10, 20, 30, 41, 5, 6, 7, 8, 100, 3, 250, 9);
        rise[0][0] = 3; rise[0][1] = 7; rise[0][2] = 5; rise[0][3] = 10;
        for (int i = 0; i < NP; i++) begin drop[0][i] = 0; rerise[0][i] = 0; end
        drop[0][2] = 6; rerise[0][2] = 12;
        set_simple(1, 2);
        run_op(1'b0, 1'b0);

        set_simple(0, 2); set_simple(1, 1000);
        run_op(1'b0, 1'b0);

        set_simple(0, 4); set_simple(1, 6);
        run_op(1'b1, 1'b0);

        set_simple(0, TMO + 1);
        run_op(1'b0, 1'b0);

        set_sums(1, 2, 3, 4, 50, 60, 70, 80, 9, 9, 9, 9);
        set_simple(0, 2); set_simple(1, 2);
        run_op(1'b0, 1'b1);
        set_sums(200, 201, 202, 203, 17, 18, 19, 23, 90, 91, 92, 93);
        run_op(1'b0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NP; i++) begin
                rs[i] = 8'($urandom); gs[i] = 8'($urandom); bs[i] = 8'($urandom);
                for (int ph = 0; ph < 2; ph++) begin
                    rise[ph][i] = int'($urandom_range(1, TMO + 2));
                    if ($urandom_range(0, 3) == 0) begin
                        drop[ph][i]   = int'($urandom_range(1, 15));
                        rerise[ph][i] = drop[ph][i] + int'($urandom_range(0, 8));
                    end else begin
                        drop[ph][i] = 0; rerise[ph][i] = 0;
                    end
                end
            end
            run_op(1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_array_scheduler.md
# pe_array_scheduler

Sequencer for an array of `NUM_PE` background-removal processing elements (`pe`). It runs one frame operation per host request:
- start the sum phase on all PEs and wait for every PE to report sum-done;
- average the per-PE channel sums into the expected background colour;
- start the background-removal phase with that colour, threshold and replacement colour, and wait for every PE to report bg-done.

It sits between the host/top-level control and the PE array, driving the PE broadcast control and configuration ports.

## Interface
Parameters
- `LOG2_NUM_PE`, 2: log2 of PE count; `NUM_PE = 2**LOG2_NUM_PE`.
- `TIMEOUT`, 1000: maximum cycles spent in either wait state before the operation is aborted.

Ports
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: host request; sampled only in IDLE.
- `threshold_in` in 8: threshold, latched on Start acceptance.
- `bg_r_in`, `bg_g_in`, `bg_b_in` in 8 each: replacement colour, latched on Start acceptance.
- `Qsd` in NUM_PE: per-PE sum-done flags.
- `Qbgd` in NUM_PE: per-PE bg-done flags.
- `red_sum`, `green_sum`, `blue_sum` in 8*NUM_PE each: per-PE channel sums; PE k occupies bits [8k+7:8k].
- `Start_Sum` out 1: one-cycle broadcast pulse.
- `Start_BgRemoval` out 1: one-cycle broadcast pulse.
- `Ack` out 1: one-cycle broadcast acknowledge.
- `red_exp`, `green_exp`, `blue_exp` out 8 each: averaged expected colour to the PEs.
- `threshold` out 8: latched threshold to the PEs.
- `desired_bg_r`, `desired_bg_g`, `desired_bg_b` out 8 each: latched replacement colour to the PEs.
- `Busy` out 1: high in every state except IDLE.
- `Done` out 1: one-cycle pulse on successful completion.
- `Error` out 1: sticky timeout flag; cleared on the next accepted Start.

## Operation
- All outputs are registered. On Reset:
  - state becomes IDLE;
  - all pulses, `Busy`, `Done` and `Error` are 0;
  - `*_exp`, `threshold` and `desired_bg_*` are 0.
- State sequence:
  - IDLE: on `Start`=1, latch the configuration inputs, clear `Error` → SUM_START.
  - SUM_START: `Start_Sum`=1 → SUM_WAIT.
  - SUM_WAIT: when `&Qsd` → SUM_ACK. On timeout → ABORT.
  - SUM_ACK: `Ack`=1; clear the accumulators; PE index := 0 → ACCUM.
  - ACCUM: each cycle, add PE[index]'s three channel sums into 10-bit accumulators (width 8+LOG2_NUM_PE); index++. Leave after NUM_PE cycles → DIVIDE.
  - DIVIDE: `*_exp` := acc >> LOG2_NUM_PE (floor, never saturates) → BG_START.
  - BG_START: `Start_BgRemoval`=1; `*_exp` already stable → BG_WAIT.
  - BG_WAIT: when `&Qbgd` → BG_ACK. On timeout → ABORT.
  - BG_ACK: `Ack`=1 → DONE.
  - DONE: `Done`=1 → IDLE.
  - ABORT: `Ack`=1; `Error` := 1 → IDLE.
- `Start` outside IDLE is ignored, not queued.
- Done flags may rise on different cycles. The wait ends on the first cycle the AND of all flags is sampled high. A flag that drops before the others rise delays completion; the scheduler does not remember earlier highs.
- The timeout counter clears on entry to each wait state. Timeout fires when the counter reaches TIMEOUT-1 without completion.
- `Reset` in any state returns to IDLE on the next edge. No Ack is issued and latched config/exp are cleared.

## Timing
- Start sampled at edge 0 → `Start_Sum` high in cycle 1.
- Sum completion sampled at edge n → `Ack` in cycle n+1, ACCUM in cycles n+2 to n+1+NUM_PE, `*_exp` valid and `Start_BgRemoval` in cycle n+3+NUM_PE.
- Bg completion sampled at edge m → `Ack` in cycle m+1, `Done` in cycle m+2, IDLE at m+3.
- Earliest accepted re-Start is sampled in the first IDLE cycle.

## Structure
- Package `pe_ctrl_pkg` holds:
  - the state enum (IDLE, SUM_START, SUM_WAIT, SUM_ACK, ACCUM, DIVIDE, BG_START, BG_WAIT, BG_ACK, DONE, ABORT);
  - the pixel width constant 8;
  - the accumulator width function.
- Sub-module `pe_sum_averager`: one-channel serial accumulate and shift, with clear, add-enable and divide strobe. Instantiated three times.

## Test plan
- NUM_PE=4, red sums 61, 63, 60, 62; green 133 ×4; blue 198, 199, 197, 198; all Qsd rise together → exp 61/133/198; exactly one pulse each of `Start_Sum`, `Start_BgRemoval` and `Done`, with cycle counts per Timing.
- All sums 255 → acc 1020, exp 255 with no overflow. All sums 0 → exp 0.
- Qsd bits rise on cycles 3, 7, 5, 10 after `Start_Sum`, with bit 2 dropping at cycle 6 and re-rising at 12 → SUM_ACK follows cycle 12 only.
- Qbgd never asserts with TIMEOUT=20 → ABORT after 20 wait cycles: `Ack` pulse, `Error`=1, no `Done`. The next Start clears `Error`.
- `Start` pulsed during BG_WAIT → ignored. `Reset` asserted in ACCUM → all outputs 0 next cycle; a fresh Start then completes normally with correct exp.
